// File: rtl/clk_pkg.sv
// ---------------------------------------------------------------------------
// clk_pkg
//   Shared definitions for the clock/lock supervision slice: the supervisor
//   state encoding, the default cycle constants and the shared counter width.
//   No ports; imported by dcm_lock_supervisor.
// ---------------------------------------------------------------------------
package clk_pkg;

    typedef enum logic [2:0] {
        RST_DCM   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } dcm_state_t;

    localparam int DEF_RST_CYCLES    = 8;      // DCM needs >= 3 CLKIN cycles of reset
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 7;
    localparam int CNT_W             = 16;     // must hold the largest cycle constant

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Plain two-flop synchroniser for quasi-static level signals crossing into
//   the clk domain. Each bit is synchronised independently, so a multi-bit
//   value is only safe here if the bits are unrelated levels (LOCKED flags,
//   AC97 status bits), not a bus.
// Ports
//   clk   in   1       destination clock
//   din   in   WIDTH   asynchronous inputs
//   dout  out  WIDTH   synchronised outputs, 2 cycles latency
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_p0;
    logic [WIDTH-1:0] sync_p1;

    // stage p0: may go metastable; p1: resolved copy
    always_ff @(posedge clk) begin
        meta_p0 <= din;
        sync_p1 <= meta_p0;
    end

    assign dout = sync_p1;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// ---------------------------------------------------------------------------
// dcm_lock_supervisor
//   Drives the shared DCM reset, watches the MAC and HUFF LOCKED flags and
//   holds the decoder in reset until both clocks are locked and settled.
//   Retries on lock timeout, settle glitch or lock loss; gives up into FAULT
//   after MAX_RETRIES extra attempts until CLEAR_FAULT_I.
// Ports
//   MASTER_CLOCK_I   in   1   master clock
//   RESET_I          in   1   synchronous, active-high reset
//   MAC_LOCKED_I     in   1   MAC DCM LOCKED (asynchronous)
//   HUFF_LOCKED_I    in   1   HUFF DCM LOCKED (asynchronous)
//   CLEAR_FAULT_I    in   1   one-cycle pulse, only honoured in FAULT
//   DCM_RESET_O      out  1   reset to both DCMs, active high
//   CLOCK_READY_O    out  1   high only in RUN
//   SYSTEM_RESETN_O  out  1   active-low decoder reset, released only in RUN
//   RETRY_COUNT_O    out  3   attempts used, saturating at 7
//   FAULT_O          out  1   high in FAULT
// ---------------------------------------------------------------------------
module dcm_lock_supervisor
    import clk_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = clk_pkg::CNT_W
) (
    input  logic       MASTER_CLOCK_I,
    input  logic       RESET_I,
    input  logic       MAC_LOCKED_I,
    input  logic       HUFF_LOCKED_I,
    input  logic       CLEAR_FAULT_I,
    output logic       DCM_RESET_O,
    output logic       CLOCK_READY_O,
    output logic       SYSTEM_RESETN_O,
    output logic [2:0] RETRY_COUNT_O,
    output logic       FAULT_O
);

    // Internal retry count is wider than the port so MAX_RETRIES above 7
    // still counts correctly while the port saturates.
    localparam int RTR_W = 8;

    function automatic logic [2:0] sat_retry(input logic [RTR_W-1:0] r);
        if (r > RTR_W'(7)) begin
            return 3'd7;
        end
        return r[2:0];
    endfunction

    logic [1:0]       locked_sync;
    logic             lock_ok;

    dcm_state_t       state;
    dcm_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [RTR_W-1:0] retries;
    logic [RTR_W-1:0] retries_nxt;
    logic [RTR_W-1:0] retry_base;
    logic             retry_req;

    logic             dcm_reset_nxt;
    logic             run_nxt;
    logic             fault_nxt;
    logic [2:0]       retry_count_nxt;

    // LOCKED flags into the master clock domain (2 cycles to lock_ok)
    sync_2ff #(
        .WIDTH (2)
    ) u_lock_sync (
        .clk  (MASTER_CLOCK_I),
        .din  ({MAC_LOCKED_I, HUFF_LOCKED_I}),
        .dout (locked_sync)
    );

    assign lock_ok = &locked_sync;

    // State, counter, retry count and registered outputs
    always_ff @(posedge MASTER_CLOCK_I) begin
        if (RESET_I) begin
            state           <= RST_DCM;
            cnt             <= '0;
            retries         <= '0;
            DCM_RESET_O     <= 1'b1;
            CLOCK_READY_O   <= 1'b0;
            SYSTEM_RESETN_O <= 1'b0;
            RETRY_COUNT_O   <= 3'd0;
            FAULT_O         <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            retries         <= retries_nxt;
            DCM_RESET_O     <= dcm_reset_nxt;
            CLOCK_READY_O   <= run_nxt;
            SYSTEM_RESETN_O <= run_nxt;
            RETRY_COUNT_O   <= retry_count_nxt;
            FAULT_O         <= fault_nxt;
        end
    end

    // Next state. The counter only runs in the timed states, so it cannot
    // wrap while parked in RUN or FAULT.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        retries_nxt = retries;
        retry_req   = 1'b0;
        retry_base  = retries;

        case (state)
            RST_DCM: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = WAIT_LOCK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // lock wins over a coincident timeout
                if (lock_ok) begin
                    state_nxt = SETTLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_req = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (!lock_ok) begin
                    retry_req = 1'b1;
                end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                // a loss after a good run starts a fresh retry budget
                if (!lock_ok) begin
                    retry_req  = 1'b1;
                    retry_base = '0;
                end
            end
            FAULT: begin
                if (CLEAR_FAULT_I) begin
                    state_nxt   = RST_DCM;
                    retries_nxt = '0;
                end
            end
            default: begin
                state_nxt = RST_DCM;
            end
        endcase

        if (retry_req) begin
            if (retry_base < RTR_W'(MAX_RETRIES)) begin
                retries_nxt = retry_base + RTR_W'(1);
                state_nxt   = RST_DCM;
            end else begin
                retries_nxt = retry_base;
                state_nxt   = FAULT;
            end
        end

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    // Outputs decoded from the next state so they move with the state
    always_comb begin
        dcm_reset_nxt   = (state_nxt == RST_DCM) || (state_nxt == FAULT);
        run_nxt         = (state_nxt == RUN);
        fault_nxt       = (state_nxt == FAULT);
        retry_count_nxt = sat_retry(retries_nxt);
    end

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_dcm_lock_supervisor
//   Bench for dcm_lock_supervisor with shortened timeout/settle constants.
//   A timeline model (phase + cycles-since-entry, lock seen through a 2-deep
//   delay line) predicts every output on every clock; a table of vectors and
//   a few hand sequences pin down exact edge timing.
// ---------------------------------------------------------------------------
module tb_dcm_lock_supervisor;

    localparam int P_RST  = 8;
    localparam int P_TO   = 200;
    localparam int P_SET  = 64;
    localparam int P_MAXR = 7;

    localparam int PH_UP    = 10;
    localparam int PH_PULSE = 11;
    localparam int PH_ACQ   = 12;
    localparam int PH_HOLD  = 13;
    localparam int PH_DEAD  = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       mac;
    logic       huff;
    logic       clr;
    logic       dcm_rst;
    logic       rdy;
    logic       rstn;
    logic [2:0] rc;
    logic       flt;

    int n_vec      = 0;
    int n_miss     = 0;
    int model_miss = 0;

    always #5 clk = ~clk;

    dcm_lock_supervisor #(
        .RST_CYCLES    (P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .SETTLE_CYCLES (P_SET),
        .MAX_RETRIES   (P_MAXR),
        .CNT_W         (16)
    ) dut (
        .MASTER_CLOCK_I  (clk),
        .RESET_I         (rst),
        .MAC_LOCKED_I    (mac),
        .HUFF_LOCKED_I   (huff),
        .CLEAR_FAULT_I   (clr),
        .DCM_RESET_O     (dcm_rst),
        .CLOCK_READY_O   (rdy),
        .SYSTEM_RESETN_O (rstn),
        .RETRY_COUNT_O   (rc),
        .FAULT_O         (flt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string name, input int e_dcm, input int e_rdy,
                             input int e_flt, input int e_rc);
        check({name, ".dcm_reset"}, int'(dcm_rst), e_dcm);
        check({name, ".clock_ready"}, int'(rdy), e_rdy);
        check({name, ".system_resetn"}, int'(rstn), e_rdy);
        check({name, ".fault"}, int'(flt), e_flt);
        check({name, ".retry_count"}, int'(rc), e_rc);
    endtask

    // Timeline reference model
    initial begin : ref_model
        bit         dly[$];
        int         ph;
        int         since;
        int         tries;
        int         n;
        bit         lok;
        bit         go_retry;
        logic [6:0] exp_o;
        logic [6:0] act_o;
        logic [2:0] rc_e;
        ph    = PH_PULSE;
        since = 0;
        tries = 0;
        n     = 0;
        forever begin
            @(posedge clk);
            n++;
            dly.push_back(mac & huff);
            lok = 1'b0;
            if (dly.size() > 2) lok = dly.pop_front();
            go_retry = 1'b0;
            if (rst) begin
                ph = PH_PULSE; since = n; tries = 0;
            end else begin
                case (ph)
                    PH_PULSE: if (n - since == P_RST) begin ph = PH_ACQ; since = n; end
                    PH_ACQ: begin
                        if (lok) begin ph = PH_HOLD; since = n; end
                        else if (n - since == P_TO) go_retry = 1'b1;
                    end
                    PH_HOLD: begin
                        if (!lok) go_retry = 1'b1;
                        else if (n - since == P_SET) begin ph = PH_UP; since = n; end
                    end
                    PH_UP: if (!lok) begin tries = 0; go_retry = 1'b1; end
                    default: if (clr) begin ph = PH_PULSE; since = n; tries = 0; end
                endcase
            end
            if (go_retry) begin
                since = n;
                if (tries < P_MAXR) begin tries++; ph = PH_PULSE; end
                else ph = PH_DEAD;
            end
            #1;
            rc_e  = (tries > 7) ? 3'd7 : 3'(tries);
            exp_o = {(ph == PH_PULSE) || (ph == PH_DEAD), ph == PH_UP, ph == PH_UP,
                     ph == PH_DEAD, rc_e};
            act_o = {dcm_rst, rdy, rstn, flt, rc};
            if (model_miss < 20) begin
                n_vec++;
                if (act_o !== exp_o) begin
                    n_miss++;
                    model_miss++;
                    $display("FAIL model cycle %0d: got %b, want %b (dcm,rdy,rstn,flt,rc)",
                             n, act_o, exp_o);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit    rst;
        bit    mac;
        bit    huff;
        int    cyc;
        int    dcm;
        int    rdy;
        int    flt;
        int    rc;
        string name;
    } vec_t;

    vec_t tv[13];

    initial begin : stim
        rst  = 1'b1;
        mac  = 1'b0;
        huff = 1'b0;
        clr  = 1'b0;

        // Cold start, lock loss in RUN, reset from RUN
        tv[0]  = '{1'b1, 1'b0, 1'b0, 5,  1, 0, 0, 0, "t_reset"};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 7,  1, 0, 0, 0, "t_pulse7"};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 1,  0, 0, 0, 0, "t_pulse_end"};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 66, 0, 0, 0, 0, "t_settle_before"};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 1,  0, 1, 0, 0, "t_release"};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1,  0, 1, 0, 0, "t_drop1"};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 1,  0, 1, 0, 0, "t_drop2"};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 1,  1, 0, 0, 1, "t_drop3"};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 7,  1, 0, 0, 1, "t_repulse7"};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 1,  0, 0, 0, 1, "t_repulse_end"};
        tv[10] = '{1'b0, 1'b1, 1'b1, 64, 0, 0, 0, 1, "t_resettle"};
        tv[11] = '{1'b0, 1'b1, 1'b1, 1,  0, 1, 0, 1, "t_rerun"};
        tv[12] = '{1'b1, 1'b1, 1'b1, 1,  1, 0, 0, 0, "t_reset_run"};

        for (int i = 0; i < 13; i++) begin
            rst  = tv[i].rst;
            mac  = tv[i].mac;
            huff = tv[i].huff;
            step(tv[i].cyc);
            check_all(tv[i].name, tv[i].dcm, tv[i].rdy, tv[i].flt, tv[i].rc);
        end

        // Only MAC locks: timeouts until FAULT
        rst = 1'b1; mac = 1'b1; huff = 1'b0;
        step(2);
        rst = 1'b0;
        step(208);
        check_all("timeout1", 1, 0, 0, 1);
        step(7);
        check("retry_pulse_high", int'(dcm_rst), 1);
        step(1);
        check("retry_pulse_low", int'(dcm_rst), 0);
        step(1663 - 216);
        check("before_fault", int'(flt), 0);
        step(1);
        check_all("fault", 1, 0, 1, 7);
        step(10);
        check_all("fault_holds", 1, 0, 1, 7);

        // Clear the fault with both clocks locking
        clr = 1'b1; mac = 1'b1; huff = 1'b1;
        step(1);
        clr = 1'b0;
        check_all("cleared", 1, 0, 0, 0);
        step(72);
        check("clear_settle", int'(rdy), 0);
        step(1);
        check_all("clear_run", 0, 1, 0, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_all("clear_ignored_run", 0, 1, 0, 0);

        // Glitch during SETTLE restarts the attempt
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(68);
        mac = 1'b0;
        step(1);
        mac = 1'b1;
        step(1);
        check_all("glitch_pre", 0, 0, 0, 0);
        step(1);
        check_all("glitch_retry", 1, 0, 0, 1);
        step(2);
        check("no_early_release", int'(rdy), 0);
        step(70);
        check("resettle_before", int'(rdy), 0);
        step(1);
        check_all("resettle_run", 0, 1, 0, 1);

        // Reset during SETTLE
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(20);
        check_all("in_settle", 0, 0, 0, 0);
        rst = 1'b1;
        step(1);
        check_all("reset_settle", 1, 0, 0, 0);
        rst = 1'b0;

        // Reset during FAULT
        mac = 1'b1; huff = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1664);
        check_all("fault_again", 1, 0, 1, 7);
        rst = 1'b1;
        step(1);
        check_all("reset_fault", 1, 0, 0, 0);
        rst = 1'b0;

        // Random lock activity, checked by the timeline model
        for (int ep = 0; ep < 80; ep++) begin
            int dur;
            rst  = ($urandom_range(0, 99) < 3);
            mac  = ($urandom_range(0, 9) != 0);
            huff = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 5) == 0);
            dur  = $urandom_range(1, 150);
            step(1);
            clr = 1'b0;
            step(dur - 1);
        end
        rst = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
